// File: rtl/branch_predictor_pkg.sv
// Shared encodings for the fetch-side branch predictor: counter states,
// allocation/miss defaults and the saturating counter step.
package branch_predictor_pkg;

  localparam int BP_ADDR_W = 32;

  localparam logic [1:0] BP_SNT = 2'b00;
  localparam logic [1:0] BP_WNT = 2'b01;
  localparam logic [1:0] BP_WT  = 2'b10;
  localparam logic [1:0] BP_ST  = 2'b11;

  localparam logic [1:0] BP_ALLOC_CTR = BP_WT;
  localparam logic [1:0] BP_MISS_PRED = BP_WNT;

  // One training step of a 2-bit counter; pins at BP_SNT and BP_ST.
  function automatic logic [1:0] bp_ctr_step(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    case (ctr)
      BP_SNT:  nxt = taken ? BP_WNT : BP_SNT;
      BP_WNT:  nxt = taken ? BP_WT  : BP_SNT;
      BP_WT:   nxt = taken ? BP_ST  : BP_WNT;
      BP_ST:   nxt = taken ? BP_ST  : BP_WT;
      default: nxt = BP_WNT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// Combinational next state of one 2-bit saturating direction counter.
module bp_sat_ctr
  import branch_predictor_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  // Saturating step, shared with anything else that trains a counter.
  always_comb begin
    ctr_next = bp_ctr_step(ctr, taken);
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry 2-bit counters, combinational lookup on
// the fetch PC, execute-stage training and a wrapping mispredict counter.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ADDR_W  = BP_ADDR_W,
  parameter int ENTRIES = 64,
  parameter int IDX_W   = 6,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic [1:0]        prediction,
  output logic [ADDR_W-1:0] addr_predicted,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_mispredict,
  output logic [CNT_W-1:0]  mispredict_cnt
);

  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic [ENTRIES-1:0] valid_r;
  logic [TAG_W-1:0]   tag_r    [ENTRIES];
  logic [ADDR_W-1:0]  target_r [ENTRIES];
  logic [1:0]         ctr_r    [ENTRIES];
  logic [CNT_W-1:0]   cnt_r;

  logic [IDX_W-1:0] lk_idx_s;
  logic [TAG_W-1:0] lk_tag_s;
  logic             lk_hit_s;
  logic [IDX_W-1:0] upd_idx_s;
  logic [TAG_W-1:0] upd_tag_s;
  logic             upd_hit_s;
  logic [1:0]       upd_ctr_next_s;
  logic [1:0]       unused_pc_bits_s;

  assign lk_idx_s  = lookup_pc[IDX_W+1:2];
  assign lk_tag_s  = lookup_pc[ADDR_W-1:IDX_W+2];
  assign upd_idx_s = upd_pc[IDX_W+1:2];
  assign upd_tag_s = upd_pc[ADDR_W-1:IDX_W+2];
  assign unused_pc_bits_s = upd_pc[1:0];

  // The valid bit gates the compare, so stale tags never produce a hit.
  assign lk_hit_s  = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s);
  assign upd_hit_s = valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s);

  bp_sat_ctr u_sat_ctr (
    .ctr      (ctr_r[upd_idx_s]),
    .taken    (upd_taken),
    .ctr_next (upd_ctr_next_s)
  );

  // Zero-latency lookup; a miss falls through to the sequential PC.
  always_comb begin
    prediction     = BP_MISS_PRED;
    addr_predicted = lookup_pc + ADDR_W'(32'd4);
    if (lk_hit_s) begin
      prediction     = ctr_r[lk_idx_s];
      addr_predicted = target_r[lk_idx_s];
    end else begin
      prediction     = BP_MISS_PRED;
      addr_predicted = lookup_pc + ADDR_W'(32'd4);
    end
  end

  // Valid bits: cleared together on reset, set when a taken miss allocates.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
    end else if (upd_valid && upd_taken) begin
      valid_r[upd_idx_s] <= 1'b1;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Entry payload; left unreset because it is unreachable until valid is set.
  always_ff @(posedge clk) begin
    if (!rst && upd_valid) begin
      if (upd_hit_s) begin
        ctr_r[upd_idx_s] <= upd_ctr_next_s;
        if (upd_taken) begin
          target_r[upd_idx_s] <= upd_target;
        end
      end else if (upd_taken) begin
        tag_r[upd_idx_s]    <= upd_tag_s;
        target_r[upd_idx_s] <= upd_target;
        ctr_r[upd_idx_s]    <= BP_ALLOC_CTR;
      end
    end
  end

  // Mispredict perf counter; wraps naturally at full scale.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (upd_valid && upd_mispredict) begin
      cnt_r <= cnt_r + CNT_W'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign mispredict_cnt = cnt_r;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, self-checking bench for branch_predictor (64 entries, 32-bit PC).
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] lookup_pc;
  logic [1:0]  prediction;
  logic [31:0] addr_predicted;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;
  logic [15:0] mispredict_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  branch_predictor #(.ADDR_W(32), .ENTRIES(64), .IDX_W(6), .CNT_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .lookup_pc      (lookup_pc),
    .prediction     (prediction),
    .addr_predicted (addr_predicted),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_mispredict (upd_mispredict),
    .mispredict_cnt (mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic misp);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt; upd_mispredict = misp;
    tick();
    upd_valid = 1'b0; upd_mispredict = 1'b0;
  endtask

  task automatic look(input string name, input logic [31:0] pc,
                      input logic [1:0] exp_pred, input logic [31:0] exp_addr);
    lookup_pc = pc;
    #1;
    n_checks++;
    if (prediction !== exp_pred) begin
      n_fail++;
      $display("FAIL %s pred: got %b want %b", name, prediction, exp_pred);
    end
    n_checks++;
    if (addr_predicted !== exp_addr) begin
      n_fail++;
      $display("FAIL %s addr: got %h want %h", name, addr_predicted, exp_addr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h999;
    upd_mispredict = 1'b1;
    tick(); tick();
    rst = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0;
    look("reset_lookup_40", 32'h40, 2'b01, 32'h44);
    n_checks++;
    if (mispredict_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %0d want 0", mispredict_cnt);
    end
  endtask

  task automatic test_train();
    upd(32'h40, 1'b1, 32'h100, 1'b1);
    look("train_hit_40", 32'h40, 2'b10, 32'h100);
    look("train_miss_80", 32'h80, 2'b01, 32'h84);
    n_checks++;
    if (mispredict_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL train_cnt: got %0d want 1", mispredict_cnt);
    end
  endtask

  task automatic test_saturate();
    logic [1:0] seq_nt [4];
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    look("sat_inc1", 32'h40, 2'b11, 32'h100);
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    look("sat_inc2_hold", 32'h40, 2'b11, 32'h100);
    seq_nt[0] = 2'b10; seq_nt[1] = 2'b01; seq_nt[2] = 2'b00; seq_nt[3] = 2'b00;
    for (int i = 0; i < 4; i++) begin
      upd(32'h40, 1'b0, 32'hDEAD_0000, 1'b0);
      look($sformatf("sat_nt%0d", i), 32'h40, seq_nt[i], 32'h100);
    end
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    look("sat_retake", 32'h40, 2'b01, 32'h100);
  endtask

  task automatic test_alias();
    look("alias_miss_140", 32'h140, 2'b01, 32'h144);
    upd(32'h140, 1'b0, 32'h777, 1'b0);
    look("alias_nt_140", 32'h140, 2'b01, 32'h144);
    look("alias_nt_40", 32'h40, 2'b01, 32'h100);
    upd(32'h140, 1'b1, 32'h200, 1'b0);
    look("alias_alloc_140", 32'h140, 2'b10, 32'h200);
    look("alias_evict_40", 32'h40, 2'b01, 32'h44);
  endtask

  task automatic test_same_cycle();
    upd(32'h40, 1'b1, 32'h250, 1'b0);
    look("same_pre", 32'h40, 2'b10, 32'h250);
    upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h300;
    look("same_old", 32'h40, 2'b10, 32'h250);
    tick();
    upd_valid = 1'b0;
    look("same_new", 32'h40, 2'b11, 32'h300);
  endtask

  task automatic test_pc_wrap();
    look("wrap_top", 32'hFFFF_FFFC, 2'b01, 32'h0);
    look("high_tag_miss", 32'h8000_0040, 2'b01, 32'h8000_0044);
  endtask

  task automatic test_reset_after_training();
    upd(32'h80, 1'b1, 32'h400, 1'b0);
    look("pre_rst_80", 32'h80, 2'b10, 32'h400);
    rst = 1'b1;
    upd_valid = 1'b1; upd_pc = 32'hC0; upd_taken = 1'b1; upd_target = 32'h500;
    upd_mispredict = 1'b1;
    tick();
    rst = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0;
    look("rst_40", 32'h40, 2'b01, 32'h44);
    look("rst_140", 32'h140, 2'b01, 32'h144);
    look("rst_80", 32'h80, 2'b01, 32'h84);
    look("rst_c0_lost", 32'hC0, 2'b01, 32'hC4);
    n_checks++;
    if (mispredict_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL rst_cnt: got %0d want 0", mispredict_cnt);
    end
  endtask

  task automatic test_cnt_wrap();
    upd_valid = 1'b1; upd_pc = 32'h1000; upd_taken = 1'b0; upd_mispredict = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    n_checks++;
    if (mispredict_cnt !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL cnt_full: got %h want ffff", mispredict_cnt);
    end
    tick();
    n_checks++;
    if (mispredict_cnt !== 16'h0000) begin
      n_fail++;
      $display("FAIL cnt_wrap: got %h want 0000", mispredict_cnt);
    end
    upd_valid = 1'b0;
    tick();
    n_checks++;
    if (mispredict_cnt !== 16'h0000) begin
      n_fail++;
      $display("FAIL cnt_unqualified: got %h want 0000", mispredict_cnt);
    end
    upd_mispredict = 1'b0;
    look("cnt_nt_no_alloc", 32'h1000, 2'b01, 32'h1004);
  endtask

  initial begin
    rst = 1'b1; lookup_pc = 32'h0; upd_valid = 1'b0; upd_pc = 32'h0;
    upd_taken = 1'b0; upd_target = 32'h0; upd_mispredict = 1'b0;
    test_reset();
    test_train();
    test_saturate();
    test_alias();
    test_same_cycle();
    test_pc_wrap();
    test_reset_after_training();
    test_cnt_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
